// File: rtl/seq_divmod_pkg.sv
// Shared types for the sequential divider: FSM state encoding and counter sizing.
package seq_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold WIDTH-1; WIDTH >= 2 keeps this at least one bit.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract the divisor.
module divmod_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  // Working remainder is WIDTH+1 bits so the shifted value never overflows.
  logic [WIDTH:0] r_sh, diff;

  assign r_sh    = {rem, din};
  assign diff    = r_sh - {1'b0, divisor};
  // No borrow out of the subtract means r_sh >= divisor.
  assign q_bit   = ~diff[WIDTH];
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];

endmodule

// File: rtl/seq_divmod.sv
// Multi-cycle unsigned divider with valid/ready on both sides; one quotient bit per cycle.
module seq_divmod
  import seq_divmod_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;  // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_nxt;

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .din     (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign dvd_nxt = {dvd_q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              dvd_q <= dividend;
              dvs_q <= divisor;
              rem_q <= '0;
              cnt   <= CW'(WIDTH - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          if (cnt == '0) begin
            quotient    <= dvd_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divmod.sv
// Bench for seq_divmod: directed cases plus exhaustive and random sweeps against plain / and %.
module tb_seq_divmod;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_divmod #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: ordinary integer division, with the all-ones / dividend convention for /0.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = a; ib = b;
    return (ib == 0) ? W'((1 << W) - 1) : W'(ia / ib);
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = a; ib = b;
    return (ib == 0) ? a : W'(ia % ib);
  endfunction

  // Issue one operation, measure latency, stall the consumer, then complete the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat, explat;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    ez = (b == 0);
    explat = ez ? 1 : W + 1;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency %0d/%0d", a, b), lat, explat);
    chk($sformatf("quot %0d/%0d", a, b), quotient, eq);
    chk($sformatf("rem %0d/%0d", a, b), remainder, er);
    chk($sformatf("dbz %0d/%0d", a, b), div_by_zero, ez);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_quot", quotient, eq);
      chk("stall_rem", remainder, er);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd3, 4'd2, 0);
    run_op(4'd3, 4'd0, 0);
    run_op(4'd14, 4'd3, 6);

    // Back-to-back: 15/4 then 2/3 with in_valid held and out_ready high.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; dividend = 4'd15; divisor = 4'd4;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd2; divisor = 4'd3;
    cyc = 1;
    while (!in_ready && cyc < 40) begin
      if (out_valid) begin
        chk("b2b_first_cycle", cyc, W + 1);
        chk("b2b_q1", quotient, 3);
        chk("b2b_r1", remainder, 3);
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_interval", cyc, W + 2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_second_latency", cyc, W + 1);
    chk("b2b_q2", quotient, 0);
    chk("b2b_r2", remainder, 2);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", in_ready, 1);

    // Leave nonzero outputs, then reset in the middle of 9/2.
    run_op(4'd14, 4'd3, 0);
    @(negedge clk);
    in_valid = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd8, 4'd8, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(W'(a), W'(b), 0);

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
